// File: rtl/satd_row_seq_if.sv
// Row-fetch and differences-stage handshake between the SATD row sequencer and its neighbours.
interface satd_row_seq_if #(
    parameter int unsigned ROWS = 8
);
    localparam int unsigned AW = $clog2(ROWS);

    logic          row_req;
    logic [AW-1:0] row_addr;
    logic          row_ack;
    logic          diff_ena;
    logic          diff_clr;
    logic          diff_valid;
    logic [AW-1:0] diff_row;

    modport master (
        output row_req, row_addr, diff_ena, diff_clr, diff_valid, diff_row,
        input  row_ack
    );

    modport slave (
        input  row_req, row_addr, diff_ena, diff_clr, diff_valid, diff_row,
        output row_ack
    );
endinterface

// File: rtl/satd_row_seq.sv
// SATD block sequencer: clears the differences stage, fetches ROWS rows from pixel memory,
// waits PIPE_LAT cycles for the downstream pipeline to drain, then pulses done.
module satd_row_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned PIPE_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    satd_row_seq_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           blk_cnt
);
    localparam int unsigned AW = $clog2(ROWS);
    localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    if (ROWS < 2 || PIPE_LAT < 1 || WIDTH < 1 || NUM_INPUTS < 1) begin : g_bad_param
        $error("satd_row_seq: ROWS >= 2, PIPE_LAT >= 1, WIDTH/NUM_INPUTS >= 1 required");
    end

    typedef enum logic [2:0] {StIdle, StClear, StLoad, StDrain, StFin} state_e;

    state_e        state;
    logic [AW-1:0] rcnt;
    logic [DW-1:0] dcnt;
    logic          row_req_q, clr_q, valid_q, busy_q, done_q;
    logic [AW-1:0] diff_row_q;
    logic          sync0, sync1, rst_sync;
    logic          accept;

    // Assertion is immediate; release takes two edges to reach the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= 1'b1;
            sync1 <= sync0;
        end
    end
    assign rst_sync = sync1;

    // Abort suppresses the capture so a cancelled row never reaches the differences stage.
    assign accept = (state == StLoad) && bus.row_ack && !abort;

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state      <= StIdle;
            rcnt       <= '0;
            dcnt       <= '0;
            row_req_q  <= 1'b0;
            clr_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_row_q <= '0;
            blk_cnt    <= '0;
        end else begin
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= accept;
            if (accept) diff_row_q <= rcnt;

            if (abort && state != StIdle) begin
                state     <= StIdle;
                rcnt      <= '0;
                dcnt      <= '0;
                row_req_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            state  <= StClear;
                            clr_q  <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                    StClear: begin
                        state     <= StLoad;
                        rcnt      <= '0;
                        row_req_q <= 1'b1;
                    end
                    StLoad: begin
                        if (bus.row_ack) begin
                            if (rcnt == AW'(ROWS - 1)) begin
                                state     <= StDrain;
                                rcnt      <= '0;
                                dcnt      <= '0;
                                row_req_q <= 1'b0;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                    end
                    StDrain: begin
                        if (dcnt == DW'(PIPE_LAT - 1)) begin
                            state   <= StFin;
                            dcnt    <= '0;
                            done_q  <= 1'b1;
                            blk_cnt <= blk_cnt + 16'd1;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    StFin: begin
                        state  <= StIdle;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.row_req    = row_req_q;
    assign bus.row_addr   = rcnt;
    assign bus.diff_clr   = clr_q;
    assign bus.diff_ena   = clr_q | accept;
    assign bus.diff_valid = valid_q;
    assign bus.diff_row   = diff_row_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: doc/satd_row_seq.md
SATD_ROW_SEQ -- requirements
Module: satd_row_seq

Interface
REQ-001 Parameter WIDTH, default 8: pixel width; sizes ORG/CUR row words as WIDTH*NUM_INPUTS bits.
REQ-002 Parameter NUM_INPUTS, default 8: pixels per row.
REQ-003 Parameter ROWS, default 8: rows per block; minimum 2.
REQ-004 Parameter PIPE_LAT, default 4: cycles from the last diff capture to the downstream result being valid; minimum 1.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  block request; sampled in IDLE only.
REQ-008 abort  input  1  synchronous cancel of the current block.
REQ-009 row_req  output  1  request for the row at row_addr from pixel memory.
REQ-010 row_addr  output  clog2(ROWS)  row index being requested.
REQ-011 row_ack  input  1  ORG/CUR for row_addr are valid this cycle.
REQ-012 diff_ena  output  1  enable to the differences stage.
REQ-013 diff_clr  output  1  active-high synchronous clear to the differences stage; qualified by diff_ena.
REQ-014 diff_valid  output  1  differences outputs hold a new row this cycle.
REQ-015 diff_row  output  clog2(ROWS)  row index carried by diff_valid.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle block-complete pulse.
REQ-018 blk_cnt  output  16  count of completed blocks.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, LOAD, DRAIN, FIN.
- IDLE -> CLEAR when start=1.
- CLEAR -> LOAD after 1 cycle.
- LOAD -> DRAIN on the ack of row ROWS-1.
- DRAIN -> FIN when the drain counter reaches PIPE_LAT-1.
- FIN -> IDLE after 1 cycle.
REQ-020 In CLEAR, diff_ena and diff_clr SHALL both be 1 for exactly one cycle; diff_clr SHALL be 0 in all other states.
REQ-021 In LOAD, row_req SHALL be 1 and row_addr SHALL hold the current row counter stable until row_ack.
REQ-022 diff_ena SHALL equal (state==LOAD && row_ack) combinationally, so the capture edge coincides with valid ORG/CUR.
REQ-023 On each accepted ack, the row counter SHALL increment by 1; the counter is 0 on entry to LOAD and never exceeds ROWS-1.
REQ-024 row_ack outside LOAD SHALL be ignored: no counter change and no diff_ena.
REQ-025 diff_valid SHALL be a registered copy of the accepted ack, asserted one cycle after it; diff_row SHALL be the acked row_addr.
REQ-026 DRAIN SHALL last exactly PIPE_LAT cycles, with row_req=0 throughout.
REQ-027 done SHALL be 1 only in FIN.
REQ-028 blk_cnt SHALL increment by 1 on entry to FIN and wrap from 0xFFFF to 0.
REQ-029 start while busy=1 SHALL be ignored; it is not queued.
REQ-030 Block throughput: start asserted in FIN's following IDLE cycle SHALL begin a new block immediately.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
- Row counter and drain counter clear to 0.
- done is not pulsed; blk_cnt is unchanged.
- Priority: abort over row_ack and over all FSM transitions.
REQ-032 abort and start together in IDLE: start SHALL win, since abort has no effect in IDLE.
REQ-033 Latency: start to first row_req = 2 cycles. With zero-wait acks, start to done = 2 + ROWS + PIPE_LAT cycles.

Reset
REQ-034 rst=0 SHALL asynchronously force:
- state = IDLE;
- row counter, drain counter, blk_cnt = 0;
- row_req, diff_ena (registered term), diff_clr, diff_valid, done, busy = 0;
- row_addr, diff_row = 0.
REQ-035 Reset asserted mid-block SHALL discard the block; after release, the block SHALL wait in IDLE for a new start.
REQ-036 Reset release SHALL be synchronised internally so that the first state change occurs no earlier than the second rising edge after deassertion.

Verification
REQ-037 Nominal block (ROWS=8, PIPE_LAT=4, row_ack tied 1, start pulse) -> diff_clr 1 cycle; 8 diff_valid with diff_row 0..7 on consecutive cycles; done 14 cycles after start; blk_cnt=1.
REQ-038 Wait states (row_ack low 3 cycles before each row) -> row_addr held stable during waits; exactly 8 diff_ena; done delayed by 24 cycles versus REQ-037.
REQ-039 abort on the cycle of the row 4 ack -> no diff_ena that cycle; IDLE next cycle; no done; blk_cnt unchanged.
REQ-040 start held high for the whole block -> exactly one block per IDLE visit; blk_cnt increments once per FIN.
REQ-041 rst=0 asserted in DRAIN -> all outputs 0 immediately without waiting for clk; no done after release until a new start.
REQ-042 Preload blk_cnt to 0xFFFF via 65535 zero-wait blocks, run one more -> blk_cnt=0 and done pulses normally.
